registers_bank_mp: RTL and testbench
====================================

Name: registers_bank_mp

Overview:
Parametrised multi-port successor of the ID-stage register bank in the MIPS pipeline.
- N combinational read ports and two write ports with fixed priority.
- Optional write-to-read bypass.
- Sequential bulk-clear engine with busy/done handshake, used by the debug unit to zero the bank between program loads without a global reset.

Parameters:
- REGISTERS_BANK_SIZE, 32, number of registers; address width AW = $clog2(REGISTERS_BANK_SIZE).
- REGISTERS_SIZE, 32, register width in bits.
- READ_PORTS, 2, number of independent read ports (1..4).
- ZERO_REG_HARDWIRED, 1, when 1 R0 ignores writes and always reads 0.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous active-low reset.
- i_wr_en_0  in  1  write enable, port 0.
- i_addr_wr_0  in  AW  write address, port 0.
- i_bus_wr_0  in  REGISTERS_SIZE  write data, port 0.
- i_wr_en_1  in  1  write enable, port 1 (priority port).
- i_addr_wr_1  in  AW  write address, port 1.
- i_bus_wr_1  in  REGISTERS_SIZE  write data, port 1.
- i_addr_rd  in  READ_PORTS*AW  packed read addresses; port k at bits [k*AW +: AW].
- o_bus_rd  out  READ_PORTS*REGISTERS_SIZE  packed read data; port k at [k*REGISTERS_SIZE +: REGISTERS_SIZE].
- i_clear  in  1  bulk-clear request, sampled in IDLE.
- o_clear_busy  out  1  high while the clear engine runs.
- o_clear_done  out  1  one-cycle pulse when the clear completes.
- o_bus_debug  out  REGISTERS_BANK_SIZE*REGISTERS_SIZE  flattened bank contents; R0 at LSBs.

Behaviour:
- Reset (i_reset=0, async):
  - all registers 0; FSM to IDLE.
  - o_clear_busy=0, o_clear_done=0, o_bus_debug=0.
  - o_bus_rd reflects zeroed bank.
- Writes:
  - registered on rising edge when enabled.
  - Both ports enabled, same address: port 1 data stored.
  - Different addresses: both stored in the same cycle.
- Out-of-range addresses (>= REGISTERS_BANK_SIZE): writes dropped; reads return 0.
- R0 with ZERO_REG_HARDWIRED=1: writes dropped, reads 0, debug slice 0.
- Reads: combinational, zero-cycle latency from i_addr_rd; each port independent; any number of ports may share an address.
- FSM states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR when i_clear=1; clear index loaded with 0.
  - CLEAR: one register zeroed per cycle, index 0..REGISTERS_BANK_SIZE-1; o_clear_busy=1. After the last index -> DONE.
  - DONE: o_clear_done=1 for exactly one cycle, o_clear_busy=0 -> IDLE.
  - Total from i_clear sample to done pulse: REGISTERS_BANK_SIZE+1 cycles.
- i_clear while in CLEAR or DONE: ignored, no queuing.
- Writes while o_clear_busy=1: dropped entirely, both ports, any address. Reads remain valid on current storage contents.
- Reset asserted mid-clear: immediate return to IDLE with the bank zeroed; no done pulse.
- o_bus_debug: registered-contents view; no bypass applied.

Optional Feature:
REGISTERS_BANK_BYPASS_EN
- Defined: a read port whose address matches an enabled, accepted write in the same cycle returns the write data combinationally.
  - Port 1 beats port 0 on double match.
  - No bypass for R0 (when hardwired), out-of-range addresses, or while busy.
- Undefined: reads always return stored contents; new data is visible the cycle after the write edge.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles after random writes -> every o_bus_rd port and o_bus_debug read 0; o_clear_busy=0.
- Dual write: port 0 writes R5=0xDEADBEEF, port 1 writes R5=0x12345678 in the same cycle -> R5 reads 0x12345678 next cycle. Separate addresses R3=0xA5A5A5A5, R4=0x5A5A5A5A -> both stored.
- R0 and range: write R0=0xFFFFFFFF -> reads 0. With REGISTERS_BANK_SIZE=10, write addr 12 -> bank unchanged; read addr 12 -> 0.
- Bypass, write R7=0xCAFEF00D while port 1 reads R7:
  - macro defined -> 0xCAFEF00D in the same cycle.
  - undefined -> old value this cycle, 0xCAFEF00D next cycle.
- Clear, bank filled with $urandom and i_clear pulsed:
  - o_clear_busy high for exactly 32 cycles, then a one-cycle o_clear_done; all registers 0.
  - Write to R9 during busy -> R9 remains 0.
- Reset mid-clear: assert i_reset=0 at clear index 10 -> immediate IDLE, bank 0, no o_clear_done. A new i_clear after release restarts cleanly from index 0.

Source files
------------

// File: rtl/registers_bank_mp_if.sv
// Bus bundle for registers_bank_mp: two write ports, packed read ports, clear handshake, debug view.
interface registers_bank_mp_if #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int REGISTERS_SIZE      = 32,
    parameter int READ_PORTS          = 2
);
    localparam int AW = (REGISTERS_BANK_SIZE > 1) ? $clog2(REGISTERS_BANK_SIZE) : 1;

    logic                                          i_wr_en_0;
    logic [AW-1:0]                                 i_addr_wr_0;
    logic [REGISTERS_SIZE-1:0]                     i_bus_wr_0;
    logic                                          i_wr_en_1;
    logic [AW-1:0]                                 i_addr_wr_1;
    logic [REGISTERS_SIZE-1:0]                     i_bus_wr_1;
    logic [READ_PORTS*AW-1:0]                      i_addr_rd;
    logic [READ_PORTS*REGISTERS_SIZE-1:0]          o_bus_rd;
    logic                                          i_clear;
    logic                                          o_clear_busy;
    logic                                          o_clear_done;
    logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] o_bus_debug;

    modport master (
        output i_wr_en_0, i_addr_wr_0, i_bus_wr_0,
        output i_wr_en_1, i_addr_wr_1, i_bus_wr_1,
        output i_addr_rd, i_clear,
        input  o_bus_rd, o_clear_busy, o_clear_done, o_bus_debug
    );

    modport slave (
        input  i_wr_en_0, i_addr_wr_0, i_bus_wr_0,
        input  i_wr_en_1, i_addr_wr_1, i_bus_wr_1,
        input  i_addr_rd, i_clear,
        output o_bus_rd, o_clear_busy, o_clear_done, o_bus_debug
    );
endinterface

// File: rtl/registers_bank_mp.sv
// Multi-port register bank: 2 prioritised write ports, READ_PORTS combinational reads, sequential bulk clear.
// Optional macro REGISTERS_BANK_BYPASS_EN forwards same-cycle accepted write data to matching read ports.
module registers_bank_mp #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int REGISTERS_SIZE      = 32,
    parameter int READ_PORTS          = 2,
    parameter int ZERO_REG_HARDWIRED  = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    registers_bank_mp_if.slave bus
);
    localparam int AW = (REGISTERS_BANK_SIZE > 1) ? $clog2(REGISTERS_BANK_SIZE) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(REGISTERS_BANK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t                                             r_state, w_state_nxt;
    logic [AW-1:0]                                      r_idx, w_idx_nxt;
    logic                                               w_busy, w_done;
    logic [REGISTERS_SIZE-1:0]                          r_bank [REGISTERS_BANK_SIZE];
    logic                                               w_wr_ok_0, w_wr_ok_1;
    logic [READ_PORTS-1:0][REGISTERS_SIZE-1:0]          w_rd;
    logic [REGISTERS_BANK_SIZE-1:0][REGISTERS_SIZE-1:0] w_dbg;

    // Address backed by real, writable storage (in range and not a hardwired R0).
    function automatic logic f_mapped(input logic [AW-1:0] a);
        return (int'(a) < REGISTERS_BANK_SIZE) && !((ZERO_REG_HARDWIRED != 0) && (a == '0));
    endfunction

    assign w_wr_ok_0 = bus.i_wr_en_0 && !w_busy && f_mapped(bus.i_addr_wr_0);
    assign w_wr_ok_1 = bus.i_wr_en_1 && !w_busy && f_mapped(bus.i_addr_wr_1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.i_clear) begin
                    w_state_nxt = CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            CLEAR: begin
                w_busy    = 1'b1;
                w_idx_nxt = r_idx + AW'(1);
                if (r_idx == LAST_IDX) w_state_nxt = DONE;
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Port 1 is tested before port 0 so it wins a same-address collision.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < REGISTERS_BANK_SIZE; i++) r_bank[i] <= '0;
        end else begin
            for (int i = 0; i < REGISTERS_BANK_SIZE; i++) begin
                if (w_busy && r_idx == AW'(i))
                    r_bank[i] <= '0;
                else if (w_wr_ok_1 && bus.i_addr_wr_1 == AW'(i))
                    r_bank[i] <= bus.i_bus_wr_1;
                else if (w_wr_ok_0 && bus.i_addr_wr_0 == AW'(i))
                    r_bank[i] <= bus.i_bus_wr_0;
            end
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        logic [AW-1:0]             w_addr;
        logic [REGISTERS_SIZE-1:0] w_data;

        assign w_addr = bus.i_addr_rd[k*AW +: AW];

        always_comb begin
            w_data = f_mapped(w_addr) ? r_bank[w_addr] : '0;
`ifdef REGISTERS_BANK_BYPASS_EN
            if (w_wr_ok_1 && bus.i_addr_wr_1 == w_addr)
                w_data = bus.i_bus_wr_1;
            else if (w_wr_ok_0 && bus.i_addr_wr_0 == w_addr)
                w_data = bus.i_bus_wr_0;
`endif
        end

        assign w_rd[k] = w_data;
    end

    always_comb begin
        for (int i = 0; i < REGISTERS_BANK_SIZE; i++) w_dbg[i] = r_bank[i];
    end

    assign bus.o_bus_rd     = w_rd;
    assign bus.o_bus_debug  = w_dbg;
    assign bus.o_clear_busy = w_busy;
    assign bus.o_clear_done = w_done;
endmodule

// File: tb/tb_registers_bank_mp.sv
// Self-checking bench for registers_bank_mp: per-cycle model compare plus directed literal checks.
module tb_registers_bank_mp;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    registers_bank_mp_if #(.REGISTERS_BANK_SIZE(N),  .REGISTERS_SIZE(32), .READ_PORTS(2)) bus ();
    registers_bank_mp_if #(.REGISTERS_BANK_SIZE(10), .REGISTERS_SIZE(32), .READ_PORTS(2)) bus_s ();

    registers_bank_mp #(.REGISTERS_BANK_SIZE(N), .REGISTERS_SIZE(32), .READ_PORTS(2), .ZERO_REG_HARDWIRED(1))
        dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));
    registers_bank_mp #(.REGISTERS_BANK_SIZE(10), .REGISTERS_SIZE(32), .READ_PORTS(2), .ZERO_REG_HARDWIRED(1))
        dut_s (.i_clk(clk), .i_reset(rst_n), .bus(bus_s));

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_dbg(input string nm, input logic [N*32-1:0] act, input logic [N*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < N; i++)
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
                    $display("FAIL %s reg%0d act=%h exp=%h", nm, i, act[i*32 +: 32], exp[i*32 +: 32]);
                    break;
                end
        end
    endtask

    // Model: architectural register contents plus a clear countdown.
    logic [31:0] mem [N];
    int          busy_cnt;
    bit          done_flag;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
            busy_cnt  <= 0;
            done_flag <= 1'b0;
        end else begin
            if (busy_cnt == 0) begin
                if (bus.i_wr_en_0 && bus.i_addr_wr_0 != 0) mem[bus.i_addr_wr_0] <= bus.i_bus_wr_0;
                if (bus.i_wr_en_1 && bus.i_addr_wr_1 != 0) mem[bus.i_addr_wr_1] <= bus.i_bus_wr_1;
            end
            if (done_flag) done_flag <= 1'b0;
            else if (busy_cnt > 0) begin
                mem[N - busy_cnt] <= '0;
                busy_cnt  <= busy_cnt - 1;
                done_flag <= (busy_cnt == 1);
            end else if (bus.i_clear) busy_cnt <= N;
        end
    end

    function automatic logic [31:0] exp_rd(input int a);
        logic [31:0] v;
        v = (a > 0 && a < N) ? mem[a] : 32'h0;
`ifdef REGISTERS_BANK_BYPASS_EN
        if (busy_cnt == 0 && a > 0 && a < N) begin
            if (bus.i_wr_en_1 && int'(bus.i_addr_wr_1) == a) v = bus.i_bus_wr_1;
            else if (bus.i_wr_en_0 && int'(bus.i_addr_wr_0) == a) v = bus.i_bus_wr_0;
        end
`endif
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            logic [N*32-1:0] e;
            for (int k = 0; k < 2; k++)
                chk($sformatf("model_rd%0d", k), bus.o_bus_rd[k*32 +: 32], exp_rd(int'(bus.i_addr_rd[k*5 +: 5])));
            chk("model_busy", bus.o_clear_busy, busy_cnt > 0);
            chk("model_done", bus.o_clear_done, done_flag);
            for (int i = 0; i < N; i++) e[i*32 +: 32] = mem[i];
            chk_dbg("model_debug", bus.o_bus_debug, e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input bit e0, input int a0, input logic [31:0] d0,
                          input bit e1, input int a1, input logic [31:0] d1);
        bus.i_wr_en_0 = e0; bus.i_addr_wr_0 = 5'(a0); bus.i_bus_wr_0 = d0;
        bus.i_wr_en_1 = e1; bus.i_addr_wr_1 = 5'(a1); bus.i_bus_wr_1 = d1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus.i_addr_rd = {5'(a1), 5'(a0)};
    endtask

    task automatic idle();
        set_wr(0, 0, 0, 0, 0, 0);
        bus.i_clear = 1'b0;
    endtask

    // Runs one clear from the current cycle; returns the number of busy cycles seen.
    task automatic run_clear(input bit poke_r9, output int cnt);
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear = 1'b0;
        cnt = 0;
        while (bus.o_clear_busy && cnt < 100) begin
            if (poke_r9 && cnt == 3) set_wr(1, 9, 32'h9999_0000, 1, 9, 32'h0000_9999);
            else set_wr(0, 0, 0, 0, 0, 0);
            bus.i_clear = (cnt == 5);
            cnt++;
            tick();
        end
        idle();
        #1;
    endtask

    initial begin
        int cnt;
        logic [31:0] exp_s;
        rst_n = 1'b0;
        idle();
        set_rd(0, 0);
        bus_s.i_wr_en_0 = 0; bus_s.i_addr_wr_0 = '0; bus_s.i_bus_wr_0 = '0;
        bus_s.i_wr_en_1 = 0; bus_s.i_addr_wr_1 = '0; bus_s.i_bus_wr_1 = '0;
        bus_s.i_addr_rd = '0; bus_s.i_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;

        // Random traffic, then reset held for three cycles.
        for (int i = 0; i < 6; i++) begin
            set_wr($urandom_range(0, 1), $urandom_range(0, N-1), $urandom,
                   $urandom_range(0, 1), $urandom_range(0, N-1), $urandom);
            set_rd($urandom_range(0, N-1), $urandom_range(0, N-1));
            tick();
        end
        set_wr(1, 6, 32'h6666_6666, 1, 8, 32'h8888_8888);
        tick();
        idle();
        set_rd(6, 8);
        rst_n = 1'b0;
        #1;
        chk("reset_rd0", bus.o_bus_rd[31:0], 32'h0);
        chk("reset_rd1", bus.o_bus_rd[63:32], 32'h0);
        chk("reset_busy", bus.o_clear_busy, 1'b0);
        chk_dbg("reset_debug", bus.o_bus_debug, '0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Same-address dual write: port 1 wins.
        set_rd(5, 5);
        set_wr(1, 5, 32'hDEAD_BEEF, 1, 5, 32'h1234_5678);
        tick();
        idle();
        #1;
        chk("dual_same_rd0", bus.o_bus_rd[31:0], 32'h1234_5678);
        chk("dual_same_rd1", bus.o_bus_rd[63:32], 32'h1234_5678);

        set_wr(1, 3, 32'hA5A5_A5A5, 1, 4, 32'h5A5A_5A5A);
        tick();
        idle();
        set_rd(3, 4);
        #1;
        chk("dual_diff_r3", bus.o_bus_rd[31:0], 32'hA5A5_A5A5);
        chk("dual_diff_r4", bus.o_bus_rd[63:32], 32'h5A5A_5A5A);

        // R0 stays zero, even for a same-cycle read.
        set_rd(0, 0);
        set_wr(1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF);
        #1 chk("r0_same_cycle", bus.o_bus_rd[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("r0_read", bus.o_bus_rd[63:32], 32'h0);
        chk("r0_debug", bus.o_bus_debug[31:0], 32'h0);

        // Write-to-read visibility on R7.
        set_wr(1, 7, 32'h1111_2222, 0, 0, 0);
        tick();
        set_rd(0, 7);
        set_wr(1, 7, 32'hCAFE_F00D, 0, 0, 0);
        #1;
`ifdef REGISTERS_BANK_BYPASS_EN
        chk("bypass_same_cycle", bus.o_bus_rd[63:32], 32'hCAFE_F00D);
`else
        chk("bypass_same_cycle", bus.o_bus_rd[63:32], 32'h1111_2222);
`endif
        tick();
        idle();
        #1 chk("bypass_next_cycle", bus.o_bus_rd[63:32], 32'hCAFE_F00D);

        // 10-entry bank: address 12 is out of range for both write and read.
        bus_s.i_wr_en_0 = 1; bus_s.i_addr_wr_0 = 4'd3;  bus_s.i_bus_wr_0 = 32'h0000_0033;
        bus_s.i_wr_en_1 = 1; bus_s.i_addr_wr_1 = 4'd12; bus_s.i_bus_wr_1 = 32'hFFFF_FFFF;
        bus_s.i_addr_rd = {4'd3, 4'd12};
        #1 chk("range_rd12_same_cycle", bus_s.o_bus_rd[31:0], 32'h0);
        tick();
        bus_s.i_wr_en_0 = 0;
        bus_s.i_wr_en_1 = 0;
        #1;
        chk("range_rd12", bus_s.o_bus_rd[31:0], 32'h0);
        chk("range_rd3", bus_s.o_bus_rd[63:32], 32'h0000_0033);
        for (int i = 0; i < 10; i++) begin
            exp_s = (i == 3) ? 32'h0000_0033 : 32'h0;
            chk($sformatf("range_debug_r%0d", i), bus_s.o_bus_debug[i*32 +: 32], exp_s);
        end

        // Fill with random data, clear, poke R9 and re-request clear while busy.
        for (int i = 0; i < N/2; i++) begin
            set_wr(1, 2*i, $urandom | 32'h1, 1, 2*i+1, $urandom | 32'h1);
            tick();
        end
        idle();
        set_rd(9, 31);
        run_clear(1'b1, cnt);
        chk("clear_busy_cycles", cnt, 32);
        chk("clear_done_pulse", bus.o_clear_done, 1'b1);
        tick();
        chk("clear_done_one_cycle", bus.o_clear_done, 1'b0);
        chk("clear_r9", bus.o_bus_rd[31:0], 32'h0);
        chk_dbg("clear_debug", bus.o_bus_debug, '0);

        // Reset in the middle of a clear, then a clean restart.
        set_wr(1, 1, 32'h0101_0101, 1, 20, 32'h2020_2020);
        tick();
        idle();
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear = 1'b0;
        repeat (10) tick();
        chk("midclr_busy_before", bus.o_clear_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midclr_busy", bus.o_clear_busy, 1'b0);
        chk("midclr_done", bus.o_clear_done, 1'b0);
        chk_dbg("midclr_debug", bus.o_bus_debug, '0);
        repeat (2) tick();
        chk("midclr_no_done", bus.o_clear_done, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("midclr_idle_done", bus.o_clear_done, 1'b0);
        set_wr(1, 2, 32'h0202_0202, 0, 0, 0);
        tick();
        idle();
        set_rd(2, 2);
        run_clear(1'b0, cnt);
        chk("restart_busy_cycles", cnt, 32);
        chk("restart_done_pulse", bus.o_clear_done, 1'b1);
        chk("restart_r2", bus.o_bus_rd[31:0], 32'h0);

        repeat (2) tick();
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
